// File: rtl/stopwatch_ctrl_if.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl_if
// Purpose : bundles the signals between the debounced button logic / digit
//           chain and the stopwatch run/pause/clear sequencer.
// Signals :
//   btn_start, btn_clear, btn_lap : single-cycle button pulses (to controller)
//   dir_down                      : requested count direction (1 = down)
//   digits_zero                   : digit chain reports all digits == 0
//   cnt_tick, cnt_rst             : one-cycle pulses to the digit chain
//   cnt_down                      : latched direction to every digit
//   lap_hold, running, expired    : status flags
//   state                         : FSM state code (debug / display)
//
// Handshake semantics: there is no valid/ready pair. Every button input is a
// self-qualifying pulse, acted on in the single cycle it is high; every output
// is registered and valid on every cycle after reset, with cnt_tick, cnt_rst
// (and expired in auto-reload builds) being one-cycle event pulses that the
// consumer must take in that cycle, as it can never stall the controller.
// Modports: master = button logic / chain side, slave = the controller.
// ---------------------------------------------------------------------------
interface stopwatch_ctrl_if;
    logic       btn_start;
    logic       btn_clear;
    logic       btn_lap;
    logic       dir_down;
    logic       digits_zero;
    logic       cnt_tick;
    logic       cnt_rst;
    logic       cnt_down;
    logic       lap_hold;
    logic       running;
    logic       expired;
    logic [1:0] state;

    modport master (
        output btn_start, btn_clear, btn_lap, dir_down, digits_zero,
        input  cnt_tick, cnt_rst, cnt_down, lap_hold, running, expired, state
    );

    modport slave (
        input  btn_start, btn_clear, btn_lap, dir_down, digits_zero,
        output cnt_tick, cnt_rst, cnt_down, lap_hold, running, expired, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
// Purpose : run/pause/clear sequencer for the stopwatch decade-counter chain.
//           Turns button pulses into count ticks, a chain reset pulse and a
//           latched count direction; provides lap freeze and countdown expiry.
// Ports   :
//   clk  - system clock
//   rst  - synchronous active-high reset
//   sw   - stopwatch_ctrl_if.slave (buttons, direction, digits_zero in;
//          cnt_tick, cnt_rst, cnt_down, lap_hold, running, expired, state out)
// Parameters:
//   TICK_DIV - clk cycles per count tick (>= 2)
//   DIV_W    - divider width, must hold TICK_DIV-1
// Build option:
//   AUTO_RELOAD_EN - when defined, countdown expiry keeps running: the tick is
//   still issued (the chain wraps to its max value) and expired is a one-cycle
//   pulse per expiry; DONE is never entered. Undefined: expiry stops in DONE
//   with a sticky expired flag.
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int TICK_DIV = 100000,
    parameter int DIV_W    = 17
) (
    input  logic clk,
    input  logic rst,
    stopwatch_ctrl_if.slave sw
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    logic [1:0]       state_q,    state_d;
    logic [DIV_W-1:0] div_q,      div_d;
    logic             cnt_tick_q, cnt_tick_d;
    logic             cnt_rst_q,  cnt_rst_d;
    logic             cnt_down_q, cnt_down_d;
    logic             lap_hold_q, lap_hold_d;
    logic             running_q,  running_d;
    logic             expired_q,  expired_d;

    logic wrap;
    logic expire_now;

    // The divider advances on every edge where the FSM was in RUN, including
    // the edge that pauses it; that is why a resume continues one count past
    // the value seen in the last running cycle.
    assign wrap       = (state_q == S_RUN) && (div_q == DIV_MAX);
    assign expire_now = wrap && cnt_down_q && sw.digits_zero;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        cnt_tick_d = 1'b0;
        cnt_rst_d  = 1'b0;
        cnt_down_d = cnt_down_q;
        lap_hold_d = lap_hold_q;
`ifdef AUTO_RELOAD_EN
        expired_d  = 1'b0;
`else
        expired_d  = expired_q;
`endif

        if (sw.btn_clear) begin
            // Clear wins over start and lap arriving in the same cycle.
            state_d    = S_IDLE;
            div_d      = '0;
            lap_hold_d = 1'b0;
            expired_d  = 1'b0;
            cnt_rst_d  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sw.btn_start) begin
                        state_d    = S_RUN;
                        cnt_down_d = sw.dir_down;
                        div_d      = '0;
                    end
                end
                S_RUN: begin
                    div_d = wrap ? '0 : div_q + 1'b1;
`ifdef AUTO_RELOAD_EN
                    // Expiry is only flagged; the tick lets the chain wrap.
                    cnt_tick_d = wrap;
                    if (expire_now) begin
                        expired_d = 1'b1;
                    end
                    if (sw.btn_start) begin
                        state_d = S_PAUSE;
                    end
`else
                    // Expiry beats a simultaneous pause: the run has ended.
                    if (expire_now) begin
                        state_d   = S_DONE;
                        expired_d = 1'b1;
                    end else begin
                        cnt_tick_d = wrap;
                        if (sw.btn_start) begin
                            state_d = S_PAUSE;
                        end
                    end
`endif
                end
                S_PAUSE: begin
                    if (sw.btn_start) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    // Only clear leaves DONE (handled above).
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (sw.btn_lap && ((state_q == S_RUN) || (state_q == S_PAUSE))) begin
                lap_hold_d = ~lap_hold_q;
            end
        end

        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            cnt_tick_q <= 1'b0;
            cnt_rst_q  <= 1'b0;
            cnt_down_q <= 1'b0;
            lap_hold_q <= 1'b0;
            running_q  <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_tick_q <= cnt_tick_d;
            cnt_rst_q  <= cnt_rst_d;
            cnt_down_q <= cnt_down_d;
            lap_hold_q <= lap_hold_d;
            running_q  <= running_d;
            expired_q  <= expired_d;
        end
    end

    assign sw.cnt_tick = cnt_tick_q;
    assign sw.cnt_rst  = cnt_rst_q;
    assign sw.cnt_down = cnt_down_q;
    assign sw.lap_hold = lap_hold_q;
    assign sw.running  = running_q;
    assign sw.expired  = expired_q;
    assign sw.state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Directed scenarios for stopwatch_ctrl with TICK_DIV=4. Stimulus pushes
// hand-computed expectations (tick cycles, chain-reset cycles, full output
// snapshots at given cycles) into queues; a negedge monitor pops and compares.
// Cycle numbers are posedge counts: "cycle e" is the state after edge e.
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  localparam int TICK_DIV = 4;
  localparam int DIV_W    = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   b;

  stopwatch_ctrl_if sw();

  stopwatch_ctrl #(
    .TICK_DIV(TICK_DIV),
    .DIV_W   (DIV_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw (sw)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          cyc;
    logic [7:0]  val;
    string       name;
  } snap_t;

  snap_t snap_q[$];
  int    exp_tick_q[$];
  int    exp_rst_q[$];

  logic [7:0] act;
  assign act = {sw.state, sw.cnt_tick, sw.cnt_rst, sw.cnt_down,
                sw.lap_hold, sw.running, sw.expired};

  function automatic logic [7:0] mk(input logic [1:0] st, input logic tk,
                                    input logic rs, input logic dn,
                                    input logic lp, input logic rn,
                                    input logic ex);
    return {st, tk, rs, dn, lp, rn, ex};
  endfunction

  task automatic push_snap(input int c, input logic [7:0] v, input string n);
    snap_t s;
    s.cyc  = c;
    s.val  = v;
    s.name = n;
    snap_q.push_back(s);
  endtask

  // Monitor: pulses are compared when the DUT presents them; snapshots when
  // their cycle comes up.
  always @(negedge clk) begin
    int t;
    snap_t s;
    while (exp_tick_q.size() != 0 && exp_tick_q[0] < cyc) begin
      t = exp_tick_q.pop_front();
      checks++; errors++;
      $display("FAIL tick_missed: no cnt_tick, expected at cycle %0d", t);
    end
    if (sw.cnt_tick === 1'b1) begin
      checks++;
      if (exp_tick_q.size() == 0) begin
        errors++;
        $display("FAIL tick_unexpected: cnt_tick at cycle %0d, none expected", cyc);
      end else begin
        t = exp_tick_q.pop_front();
        if (t != cyc) begin
          errors++;
          $display("FAIL tick_cycle: cnt_tick at cycle %0d, expected cycle %0d", cyc, t);
        end
      end
    end
    while (exp_rst_q.size() != 0 && exp_rst_q[0] < cyc) begin
      t = exp_rst_q.pop_front();
      checks++; errors++;
      $display("FAIL rst_missed: no cnt_rst, expected at cycle %0d", t);
    end
    if (sw.cnt_rst === 1'b1) begin
      checks++;
      if (exp_rst_q.size() == 0) begin
        errors++;
        $display("FAIL rst_unexpected: cnt_rst at cycle %0d, none expected", cyc);
      end else begin
        t = exp_rst_q.pop_front();
        if (t != cyc) begin
          errors++;
          $display("FAIL rst_cycle: cnt_rst at cycle %0d, expected cycle %0d", cyc, t);
        end
      end
    end
    while (snap_q.size() != 0 && snap_q[0].cyc <= cyc) begin
      s = snap_q.pop_front();
      checks++;
      if (s.cyc != cyc) begin
        errors++;
        $display("FAIL %s: snapshot for cycle %0d skipped (now %0d)", s.name, s.cyc, cyc);
      end else if (act !== s.val) begin
        errors++;
        $display("FAIL %s: cycle %0d got {st,tk,rs,dn,lp,rn,ex}=%b expected %b",
                 s.name, cyc, act, s.val);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Return just after edge e-1, so the next inputs are sampled at edge e.
  task automatic goto_edge(input int e);
    while (cyc < e - 1) step(1);
  endtask

  task automatic press(input logic s, input logic c, input logic l);
    sw.btn_start = s;
    sw.btn_clear = c;
    sw.btn_lap   = l;
    step(1);
    sw.btn_start = 1'b0;
    sw.btn_clear = 1'b0;
    sw.btn_lap   = 1'b0;
  endtask

  task automatic do_clear(input int e, input logic dn);
    exp_rst_q.push_back(e);
    push_snap(e,     mk(ST_IDLE, 1'b0, 1'b1, dn, 1'b0, 1'b0, 1'b0), "clear_pulse");
    push_snap(e + 1, mk(ST_IDLE, 1'b0, 1'b0, dn, 1'b0, 1'b0, 1'b0), "clear_idle");
    goto_edge(e);
    press(1'b0, 1'b1, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst            = 1'b1;
    sw.btn_start   = 1'b1;  // must be ignored while in reset
    sw.btn_clear   = 1'b0;
    sw.btn_lap     = 1'b1;
    sw.dir_down    = 1'b0;
    sw.digits_zero = 1'b0;
    push_snap(2, 8'h00, "reset");
    push_snap(3, 8'h00, "reset_btn_override");
    step(3);
    rst          = 1'b0;
    sw.btn_start = 1'b0;
    sw.btn_lap   = 1'b0;

    // Up count: ticks exactly every TICK_DIV cycles from the start edge.
    step(2);
    b = cyc + 1;
    push_snap(b,     mk(ST_RUN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "start_up");
    push_snap(b + 4, mk(ST_RUN, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "first_tick");
    push_snap(b + 5, mk(ST_RUN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "tick_one_cycle");
    exp_tick_q.push_back(b + 4);
    exp_tick_q.push_back(b + 8);
    exp_tick_q.push_back(b + 12);
    sw.dir_down = 1'b0;
    goto_edge(b);
    press(1'b1, 1'b0, 1'b0);
    do_clear(b + 14, 1'b0);

    // Pause at +6, resume at +20: divider resumes from 2, tick at +22.
    step(2);
    b = cyc + 1;
    push_snap(b,      mk(ST_RUN,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "start_p");
    push_snap(b + 6,  mk(ST_PAUSE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "pause");
    push_snap(b + 13, mk(ST_PAUSE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "pause_hold");
    push_snap(b + 20, mk(ST_RUN,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "resume");
    push_snap(b + 22, mk(ST_RUN,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "resume_tick");
    exp_tick_q.push_back(b + 4);
    exp_tick_q.push_back(b + 22);
    goto_edge(b);
    press(1'b1, 1'b0, 1'b0);
    goto_edge(b + 6);
    press(1'b1, 1'b0, 1'b0);
    goto_edge(b + 20);
    press(1'b1, 1'b0, 1'b0);
    do_clear(b + 24, 1'b0);

    // Start + clear + lap in one cycle while running with lap held.
    step(2);
    b = cyc + 1;
    push_snap(b,     mk(ST_RUN,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "start_c");
    push_snap(b + 1, mk(ST_RUN,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), "lap_before_clr");
    push_snap(b + 3, mk(ST_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "clear_priority");
    push_snap(b + 4, mk(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "clear_no_tick");
    exp_rst_q.push_back(b + 3);
    goto_edge(b);
    press(1'b1, 1'b0, 1'b0);
    goto_edge(b + 1);
    press(1'b0, 1'b0, 1'b1);
    goto_edge(b + 3);
    press(1'b1, 1'b1, 1'b1);

    // Countdown expiry at the second wrap.
    step(3);
    b = cyc + 1;
    sw.dir_down    = 1'b1;
    sw.digits_zero = 1'b0;
    push_snap(b,     mk(ST_RUN, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), "start_down");
    push_snap(b + 4, mk(ST_RUN, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), "down_tick");
    exp_tick_q.push_back(b + 4);
`ifdef AUTO_RELOAD_EN
    push_snap(b + 8,  mk(ST_RUN, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1), "reload_expire");
    push_snap(b + 9,  mk(ST_RUN, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), "reload_pulse_end");
    push_snap(b + 12, mk(ST_RUN, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1), "reload_again");
    exp_tick_q.push_back(b + 8);
    exp_tick_q.push_back(b + 12);
    goto_edge(b);
    press(1'b1, 1'b0, 1'b0);
    goto_edge(b + 5);
    sw.digits_zero = 1'b1;
    do_clear(b + 13, 1'b1);
`else
    push_snap(b + 8,  mk(ST_DONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), "expire_done");
    push_snap(b + 10, mk(ST_DONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), "done_start_ign");
    push_snap(b + 11, mk(ST_DONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), "done_lap_ign");
    goto_edge(b);
    press(1'b1, 1'b0, 1'b0);
    goto_edge(b + 5);
    sw.digits_zero = 1'b1;
    goto_edge(b + 10);
    press(1'b1, 1'b0, 1'b0);
    goto_edge(b + 11);
    press(1'b0, 1'b0, 1'b1);
    do_clear(b + 12, 1'b1);
`endif
    sw.digits_zero = 1'b0;

    // Lap toggles and a mid-run direction change.
    step(2);
    b = cyc + 1;
    sw.dir_down = 1'b0;
    push_snap(b,     mk(ST_RUN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "start_lap");
    push_snap(b + 2, mk(ST_RUN, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), "lap_on");
    push_snap(b + 4, mk(ST_RUN, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), "lap_tick");
    push_snap(b + 5, mk(ST_RUN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "lap_off");
    push_snap(b + 9, mk(ST_RUN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "dir_ignored");
    exp_tick_q.push_back(b + 4);
    exp_tick_q.push_back(b + 8);
    goto_edge(b);
    press(1'b1, 1'b0, 1'b0);
    goto_edge(b + 2);
    press(1'b0, 1'b0, 1'b1);
    sw.dir_down = 1'b1;
    goto_edge(b + 5);
    press(1'b0, 1'b0, 1'b1);
    do_clear(b + 10, 1'b0);
    push_snap(b + 12, mk(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "lap_idle_ign");
    goto_edge(b + 12);
    press(1'b0, 1'b0, 1'b1);

    // Drain and report anything the monitor never saw.
    step(6);
    foreach (exp_tick_q[i]) begin
      checks++; errors++;
      $display("FAIL tick_left: tick for cycle %0d never seen", exp_tick_q[i]);
    end
    foreach (exp_rst_q[i]) begin
      checks++; errors++;
      $display("FAIL rst_left: cnt_rst for cycle %0d never seen", exp_rst_q[i]);
    end
    foreach (snap_q[i]) begin
      checks++; errors++;
      $display("FAIL %s_left: snapshot for cycle %0d never taken", snap_q[i].name, snap_q[i].cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
